// File: rtl/bcd_serial_rx.sv
// bcd_serial_rx: framed serial BCD digit receiver.
// Start, 4 data bits LSB first, stop; enable-strobed.
module bcd_serial_rx #(
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_a_n,
  input  logic                    enable,
  input  logic                    serial_in,
  input  logic                    clr,
  output logic [3:0]              bcd_digit,
  output logic [4*NUM_DIGITS-1:0] bcd_value,
  output logic                    digit_valid,
  output logic                    bcd_err,
  output logic                    frame_err,
  output logic                    busy,
  output logic [3:0]              digit_count
);

  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]   nibble_q, nibble_d;
  logic [3:0]   digit_q, digit_d;
  logic [W-1:0] value_q, value_d;
  logic [3:0]   count_q, count_d;
  logic         valid_q, valid_d;
  logic         berr_q, berr_d;
  logic         ferr_q, ferr_d;
  logic         busy_q, busy_d;

  logic [W-1:0] value_base;
  logic [W+3:0] value_ext;
  logic [3:0]   count_base;
  logic [3:0]   count_inc;

  // clr zeroes the base so a same-edge accept lands on a clean register
  always_comb begin
    value_base = clr ? '0 : value_q;
    count_base = clr ? 4'd0 : count_q;
    value_ext  = {value_base, nibble_q};
    if (count_base == 4'hF) begin
      count_inc = count_base;
    end else begin
      count_inc = count_base + 4'd1;
    end
  end

  // next-state, datapath and pulse decode
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    nibble_d  = nibble_q;
    digit_d   = digit_q;
    value_d   = value_base;
    count_d   = count_base;
    valid_d   = 1'b0;
    berr_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !serial_in) begin
          state_d   = DATA;
          bit_cnt_d = 2'd0;
          nibble_d  = 4'd0;
        end
      end
      DATA: begin
        if (enable) begin
          nibble_d[bit_cnt_q] = serial_in;
          bit_cnt_d = bit_cnt_q + 2'd1;
          if (bit_cnt_q == 2'd3) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (enable) begin
          state_d = IDLE;
          if (!serial_in) begin
            ferr_d = 1'b1;
          end else if (nibble_q > 4'd9) begin
            berr_d = 1'b1;
          end else begin
            digit_d = nibble_q;
            value_d = value_ext[W-1:0];
            count_d = count_inc;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 2'd0;
      nibble_q  <= 4'd0;
      digit_q   <= 4'd0;
      value_q   <= '0;
      count_q   <= 4'd0;
      valid_q   <= 1'b0;
      berr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      nibble_q  <= nibble_d;
      digit_q   <= digit_d;
      value_q   <= value_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      berr_q    <= berr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign bcd_digit   = digit_q;
  assign bcd_value   = value_q;
  assign digit_count = count_q;
  assign digit_valid = valid_q;
  assign bcd_err     = berr_q;
  assign frame_err   = ferr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_bcd_serial_rx.sv
// tb_bcd_serial_rx: random and directed frames
// against a digit-history reference model.
module tb_bcd_serial_rx;

  localparam int ND = 2;

  logic          clk = 1'b0;
  logic          rst_a_n = 1'b0;
  logic          enable = 1'b0;
  logic          serial_in = 1'b1;
  logic          clr = 1'b0;
  logic [3:0]    bcd_digit;
  logic [4*ND-1:0] bcd_value;
  logic          digit_valid;
  logic          bcd_err;
  logic          frame_err;
  logic          busy;
  logic [3:0]    digit_count;

  bcd_serial_rx #(.NUM_DIGITS(ND)) dut (
    .clk(clk),
    .rst_a_n(rst_a_n),
    .enable(enable),
    .serial_in(serial_in),
    .clr(clr),
    .bcd_digit(bcd_digit),
    .bcd_value(bcd_value),
    .digit_valid(digit_valid),
    .bcd_err(bcd_err),
    .frame_err(frame_err),
    .busy(busy),
    .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int hist[$];
  int m_cnt = 0;
  int m_last = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_value();
    logic [31:0] v;
    v = 0;
    for (int k = 0; k < ND && k < hist.size(); k++)
      v = v | (32'(hist[k]) << (4 * k));
    return v;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_cnt = 0;
    m_last = 0;
  endtask

  task automatic model_clr();
    hist.delete();
    m_cnt = 0;
  endtask

  task automatic model_accept(input int nib);
    hist.push_front(nib);
    if (hist.size() > 8) void'(hist.pop_back());
    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    m_last = nib;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".digit"}, 32'(bcd_digit), 32'(m_last));
    check({tag, ".value"}, 32'(bcd_value), exp_value());
    check({tag, ".count"}, 32'(digit_count), 32'(m_cnt));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".pulses"},
          32'({digit_valid, bcd_err, frame_err}), 0);
  endtask

  // gap < 0: exactly one disabled cycle before bits 1..5
  task automatic send_frame(input logic [3:0] nib,
                            input logic stop,
                            input int gap,
                            input logic clr_stop);
    logic [5:0] bits;
    int ngap;
    logic ev, eb, ef;
    bits = {stop, nib, 1'b0};
    for (int i = 0; i < 6; i++) begin
      if (gap < 0) ngap = (i > 0) ? 1 : 0;
      else begin
        ngap = 0;
        while (ngap < 4 && $urandom_range(99) < gap)
          ngap++;
      end
      for (int g = 0; g < ngap; g++) begin
        enable = 1'b0;
        serial_in = 1'($urandom);
        @(posedge clk); #1;
        check_quiet("gap");
        check("gap.busy", 32'(busy), 32'(i > 0));
      end
      enable = 1'b1;
      serial_in = bits[i];
      clr = clr_stop && (i == 5);
      @(posedge clk); #1;
      clr = 1'b0;
      if (i < 5) begin
        check_quiet("bit");
        check("bit.busy", 32'(busy), 1);
      end
    end
    serial_in = 1'b1;
    ef = !stop;
    eb = stop && (nib > 9);
    ev = stop && (nib <= 9);
    if (clr_stop) model_clr();
    if (ev) model_accept(int'(nib));
    check("stop.valid", 32'(digit_valid), 32'(ev));
    check("stop.berr", 32'(bcd_err), 32'(eb));
    check("stop.ferr", 32'(frame_err), 32'(ef));
    check("stop.busy", 32'(busy), 0);
    check_regs("stop");
  endtask

  task automatic idle_cycle(input logic c);
    enable = 1'b1;
    serial_in = 1'b1;
    clr = c;
    @(posedge clk); #1;
    clr = 1'b0;
    if (c) model_clr();
    check_quiet("idle");
    check("idle.busy", 32'(busy), 0);
    check_regs("idle");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".out"},
          32'({bcd_digit, bcd_value, digit_count,
               digit_valid, bcd_err, frame_err, busy}),
          0);
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    #11;
    rst_a_n = 1'b1;
    model_reset();
    idle_cycle(1'b0);

    send_frame(4'd5, 1'b1, 0, 1'b0);
    check("t1.value", 32'(bcd_value), 32'h05);
    send_frame(4'd3, 1'b1, 0, 1'b0);
    check("t2.value53", 32'(bcd_value), 32'h53);
    send_frame(4'd9, 1'b1, 0, 1'b0);
    check("t2.value39", 32'(bcd_value), 32'h39);
    check("t2.count", 32'(digit_count), 3);
    idle_cycle(1'b0);
    send_frame(4'd12, 1'b1, 0, 1'b0);
    send_frame(4'd5, 1'b0, 0, 1'b0);
    send_frame(4'd7, 1'b1, -1, 1'b0);
    check("t4.digit", 32'(bcd_digit), 7);

    enable = 1'b1;
    serial_in = 1'b0;
    @(posedge clk); #1;
    serial_in = 1'b1;
    @(posedge clk); #1;
    serial_in = 1'b0;
    @(posedge clk); #2;
    rst_a_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("t5.async");
    @(posedge clk); #1;
    check_all_zero("t5.held");
    rst_a_n = 1'b1;
    serial_in = 1'b1;
    idle_cycle(1'b0);
    send_frame(4'd2, 1'b1, 0, 1'b0);
    check("t5.digit", 32'(bcd_digit), 2);

    send_frame(4'd3, 1'b1, 0, 1'b0);
    send_frame(4'd9, 1'b1, 0, 1'b0);
    check("t6.pre", 32'(bcd_value), 32'h39);
    send_frame(4'd4, 1'b1, 0, 1'b1);
    check("t6.value", 32'(bcd_value), 32'h04);
    check("t6.count", 32'(digit_count), 1);
    for (int n = 0; n < 16; n++)
      send_frame(4'($urandom_range(9)), 1'b1, 0, 1'b0);
    check("t6.sat", 32'(digit_count), 15);
    idle_cycle(1'b1);

    for (int n = 0; n < 300; n++) begin
      logic [3:0] nib;
      logic stop;
      nib = 4'($urandom_range(15));
      if ($urandom_range(3) != 0) nib = 4'($urandom_range(9));
      stop = ($urandom_range(9) != 0);
      send_frame(nib, stop,
                 ($urandom_range(1) != 0) ? 30 : 0,
                 ($urandom_range(19) == 0));
      if ($urandom_range(3) == 0)
        idle_cycle($urandom_range(29) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
